// File: rtl/ldw_muldiv.sv
// ---------------------------------------------------------------------------
// ldw_muldiv -- iterative 32x32 multiply / 32/32 divide unit.
//
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// clock. An accepted operation takes 34 cycles from the start edge to done.
//
// Ports:
//   clk          rising-edge clock for all state
//   clr          synchronous active-high reset; abandons any operation
//   start        begin an operation (sampled only while busy=0)
//   op[1:0]      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a[31:0]      operand A / dividend
//   b[31:0]      operand B / divisor
//   busy         high while an operation is in progress
//   done         one-cycle pulse: hi/lo hold the new result
//   hi[31:0]     product[63:32] or remainder
//   lo[31:0]     product[31:0]  or quotient
//   o_dbg_state  current FSM state (0 IDLE, 1 RUN, 2 FIX)
//
// Handshake: start is taken at a rising edge only when busy=0 (IDLE); while
// busy=1 start is ignored, nothing is queued. done pulses for the single
// cycle after the result is written, and since the FSM is already IDLE in
// that cycle a new start may be presented alongside done.
// ---------------------------------------------------------------------------
module ldw_muldiv (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;

    logic [4:0]   r_cnt;     // step counter; wraps 31->0 on the last step
    logic [1:0]   r_op;
    logic [31:0]  r_a;       // original operand A (remainder sign, div-by-zero)
    logic         r_b_neg;   // sign of original operand B
    logic [31:0]  r_opb;     // multiplicand / divisor magnitude
    // Working register. Multiply: {partial product high, multiplier/low
    // product}. Divide: {partial remainder, dividend shifting into quotient}.
    logic [63:0]  r_p;
    logic         r_done;
    logic [31:0]  r_hi;
    logic [31:0]  r_lo;

    logic [31:0]  w_a_neg;
    logic [31:0]  w_b_neg;
    logic [32:0]  w_sum;
    logic [63:0]  w_mul_p;
    logic [32:0]  w_shift;
    logic [33:0]  w_diff;
    logic [63:0]  w_div_p;
    logic [63:0]  w_p_neg;
    logic [31:0]  w_quo_neg;
    logic [31:0]  w_rem_neg;
    logic         w_sign_diff;
    logic         w_div0;
    logic [63:0]  w_res;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy        = (r_state != S_IDLE);
        o_dbg_state = r_state;
    end

    // ------------------------------------------------------------------
    // Operand conditioning: signed ops work on magnitudes.
    // ------------------------------------------------------------------
    assign w_a_neg = ~a + 32'd1;
    assign w_b_neg = ~b + 32'd1;

    // Multiply step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole 65-bit result right.
    assign w_sum   = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_opb} : 33'd0);
    assign w_mul_p = {w_sum, r_p[31:1]};

    // Divide step: shift the next dividend bit into the remainder and try to
    // subtract. A 33-bit shifted remainder always exceeds the divisor, so the
    // restored or reduced remainder always fits back into 32 bits.
    assign w_shift = {r_p[63:32], r_p[31]};
    assign w_diff  = {1'b0, w_shift} - {2'b00, r_opb};
    assign w_div_p = w_diff[33] ? {w_shift[31:0], r_p[30:0], 1'b0}
                                : {w_diff[31:0],  r_p[30:0], 1'b1};

    // ------------------------------------------------------------------
    // Final sign correction, applied once in FIX.
    // ------------------------------------------------------------------
    assign w_p_neg     = ~r_p + 64'd1;
    assign w_quo_neg   = ~r_p[31:0] + 32'd1;
    assign w_rem_neg   = ~r_p[63:32] + 32'd1;
    assign w_sign_diff = r_a[31] ^ r_b_neg;
    assign w_div0      = (r_opb == 32'd0);

    always_comb begin
        w_res = r_p;
        case (r_op)
            2'b00: w_res = r_p;
            2'b01: w_res = w_sign_diff ? w_p_neg : r_p;
            2'b10: w_res = w_div0 ? {r_a, 32'hFFFF_FFFF} : r_p;
            default: begin
                if (w_div0) begin
                    w_res = {r_a, 32'hFFFF_FFFF};
                end else begin
                    // Quotient truncates toward zero; remainder follows dividend.
                    w_res = {(r_a[31] ? w_rem_neg : r_p[63:32]),
                             (w_sign_diff ? w_quo_neg : r_p[31:0])};
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt   <= 5'd0;
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b_neg <= 1'b0;
            r_opb   <= 32'd0;
            r_p     <= 64'd0;
            r_done  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= a;
                        r_b_neg <= b[31];
                        r_opb   <= (op[0] && b[31]) ? w_b_neg : b;
                        r_p     <= {32'd0, ((op[0] && a[31]) ? w_a_neg : a)};
                        r_cnt   <= 5'd0;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 5'd1;
                    r_p   <= r_op[1] ? w_div_p : w_mul_p;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    r_hi   <= w_res[63:32];
                    r_lo   <= w_res[31:0];
                end
                default: begin
                end
            endcase
        end
    end

    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_ldw_muldiv.sv
// ---------------------------------------------------------------------------
// Bench for ldw_muldiv: directed vector table, hand-written sequences for
// ignored start, clr mid-operation and clr/start priority, then randomized
// operations scored against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_ldw_muldiv;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    ldw_muldiv dut (
        .clk        (clk),
        .clr        (clr),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .o_dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // scoreboard helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] m_a,
                                          input logic [31:0] m_b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      rm;
        logic [63:0] r;
        sa = longint'($signed(m_a));
        sb = longint'($signed(m_b));
        case (m_op)
            2'd0: r = {32'd0, m_a} * {32'd0, m_b};
            2'd1: r = 64'(sa * sb);
            2'd2: r = (m_b == 32'd0) ? {m_a, 32'hFFFF_FFFF} : {m_a % m_b, m_a / m_b};
            default: begin
                if (m_b == 32'd0) begin
                    r = {m_a, 32'hFFFF_FFFF};
                end else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // driver: called at a negedge, returns at the negedge where done=1
    // (or after the cycle budget). poke_cyc >= 0 pulses a stray start with
    // a different operand A in that cycle of the run.
    // ------------------------------------------------------------------
    task automatic run_op(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                          input int poke_cyc, output logic [63:0] res, output int lat,
                          output bit busy_ok);
        logic [63:0] hold;
        int cyc;
        hold  = {hi, lo};
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        @(negedge clk);
        // operands are scrambled after the start edge; the DUT must not care
        start   = 1'b0;
        op      = 2'($urandom);
        a       = $urandom;
        b       = $urandom;
        busy_ok = 1'b1;
        cyc     = 0;
        while (!done && cyc < 100) begin
            if (!busy || ({hi, lo} !== hold)) busy_ok = 1'b0;
            if (cyc == poke_cyc) begin
                start = 1'b1;
                a     = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        lat   = cyc + 1;   // count includes the start edge
        res   = {hi, lo};
        if (done && busy) busy_ok = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // test
    // ------------------------------------------------------------------
    initial begin
        logic [63:0] res;
        int          lat;
        bit          bok;
        bit          saw_done;
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2]  = '{2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{2'd2, 32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
        vecs[5]  = '{2'd3, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF};
        vecs[6]  = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[7]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8]  = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9]  = '{2'd0, 32'd0,         32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{2'd2, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF};
        vecs[11] = '{2'd1, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        vecs[12] = '{2'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};

        // reset
        clr   = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hi/lo", {hi, lo}, 64'd0);

        // directed vectors, issued back to back (each start lands on done)
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, res, lat, bok);
            check($sformatf("vec%0d result", i), res, {vecs[i].hi, vecs[i].lo});
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd34);
            check($sformatf("vec%0d busy/hold", i), 64'(bok), 64'd1);
        end

        // stray start with a=9 during MULTU 6*7 is ignored
        run_op(2'd0, 32'd6, 32'd7, 4, res, lat, bok);
        check("ignored start result", res, {32'd0, 32'd42});
        check("ignored start latency", 64'(lat), 64'd34);
        check("ignored start busy", 64'(bok), 64'd1);
        // done cycle: one more cycle later done must be gone and no restart
        @(negedge clk);
        check("done single pulse", 64'(done), 64'd0);
        check("no restart after stray start", 64'(busy), 64'd0);

        // clr at cycle 10 of DIVU 100/7: abandoned, no done
        start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("mid-run busy", 64'(busy), 64'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr busy", 64'(busy), 64'd0);
        check("clr hi/lo", {hi, lo}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        check("clr no done", 64'(saw_done), 64'd0);
        run_op(2'd2, 32'd100, 32'd7, -1, res, lat, bok);
        check("after clr divu", res, {32'd2, 32'd14});
        check("after clr latency", 64'(lat), 64'd34);

        // clr while in FIX: no done, result not written
        @(negedge clk);
        start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        check("fix busy", 64'(busy), 64'd1);
        check("fix no early done", 64'(done), 64'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("fix clr done", 64'(done), 64'd0);
        check("fix clr busy", 64'(busy), 64'd0);
        check("fix clr hi/lo", {hi, lo}, 64'd0);

        // clr and start at the same edge: clr wins
        start = 1'b1; clr = 1'b1; op = 2'd0; a = 32'd2; b = 32'd2;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        check("clr over start busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("clr over start idle", 64'(busy), 64'd0);

        // randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       r_a = 32'h8000_0000;
                1:       r_a = 32'($urandom_range(0, 20));
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       r_b = 32'd0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = 32'($urandom_range(1, 20));
                default: r_b = $urandom;
            endcase
            exp_q.push_back(model(r_op, r_a, r_b));
            run_op(r_op, r_a, r_b, -1, res, lat, bok);
            check($sformatf("rand%0d op%0d %h %h", i, r_op, r_a, r_b), res, exp_q.pop_front());
            check($sformatf("rand%0d latency", i), 64'(lat), 64'd34);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ldw_muldiv.md
LDW_MULDIV -- requirements
Module: ldw_muldiv

Interface
Parameters: none; width fixed at 32.
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port clr, input, 1, synchronous active-high reset.
REQ-003 SHALL have port start, input, 1, request to begin an operation; sampled only when busy=0.
REQ-004 SHALL have port op, input, 2, operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL have port a, input, 32, operand A / dividend, driven from register-file read port qa.
REQ-006 SHALL have port b, input, 32, operand B / divisor, driven from register-file read port qb.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking hi/lo valid.
REQ-009 SHALL have port hi, output, 32, product[63:32] or remainder.
REQ-010 SHALL have port lo, output, 32, product[31:0] or quotient.

Function
REQ-011 SHALL implement FSM states IDLE, RUN and FIX; IDLE is the only state with busy=0.
REQ-012 SHALL, in IDLE with start=1 at edge E0, latch op, a and b, load |a| and |b| (signed ops) or raw a and b (unsigned ops), clear the 5-bit iteration counter, and go to RUN.
REQ-013 SHALL perform exactly one shift-add (multiply) or restoring shift-subtract (divide) step per clock in RUN, at edges E1..E32.
REQ-014 SHALL move RUN->FIX at E32, when the counter wraps from 31 to 0.
REQ-015 SHALL, at FIX edge E33, apply sign correction, write hi/lo, go to IDLE, and drive done=1 for exactly the cycle following E33.
REQ-016 SHALL hold busy=1 from after E0 through E33; total latency is start edge to done = 34 cycles.
REQ-017 SHALL keep hi/lo stable from done until the next accepted start's E33; intermediate values SHALL NOT appear on hi/lo.
REQ-018 SHALL ignore start while busy=1; no queuing and no restart.
REQ-019 SHALL ignore changes on a, b and op after E0.
REQ-020 SHALL negate the 64-bit product for MULT when sign(a) != sign(b).
REQ-021 SHALL, for DIV, negate the quotient when sign(a) != sign(b) and give the remainder the sign of the dividend.
REQ-022 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000, hi=0, with no trap.
REQ-023 SHALL, when b=0 for DIVU or DIV, produce lo=0xFFFFFFFF and hi=a (original value), with the same 34-cycle latency.
REQ-024 SHALL allow a new start to be accepted in the same cycle that done=1, since the FSM is already in IDLE.

Reset
REQ-025 SHALL, when clr=1 at a clock edge, force state=IDLE, busy=0, done=0, hi=0, lo=0 and counter=0.
REQ-026 SHALL abandon any operation in progress on clr, even mid-RUN or in FIX, with no done pulse.
REQ-027 SHALL give clr priority over start at the same edge.

Verification
REQ-028 SHALL cover: MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done 34 cycles after the start edge, hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 SHALL cover: MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-030 SHALL cover: DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 SHALL cover: DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=0x00000005; DIV a=0xFFFFFFF0 b=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFF0.
REQ-032 SHALL cover: MULTU 6*7, second start pulsed at cycle 5 with a=9 -> ignored, result lo=42, hi=0; back-to-back start on the done cycle accepted.
REQ-033 SHALL cover: DIVU 100/7 with clr asserted at cycle 10 -> busy=0, hi=lo=0 next cycle, no done; a new DIVU 100/7 afterwards -> lo=14, hi=2.
